// File: rtl/radix4_datapath.sv
// radix4_datapath: datapath for a radix-4 Booth multiplier, driven by an external
// controller through load strobes and selects. One Booth digit (two multiplier bits)
// is retired per cycle on signed two's-complement operands. All state updates on the
// falling edge of clk to match the controller.
//
// Ports
//   clk      in   clock (falling-edge registers)
//   rst      in   synchronous active-high reset, overrides every strobe
//   in_a     in   multiplicand (signed, N bits)
//   in_b     in   multiplier (signed, N bits)
//   ld[4:0]  in   strobes: 0 load M, 1 init A/Q, 2 accumulate, 3 shift, 4 counter
//   sel[4:0] in   selects: 0 addend enable, 1 counter load(1)/decrement(0),
//                 4 product capture, 3:2 ignored
//   flag     out  counter is zero
//   product  out  signed 2N-bit product {A[N-1:0], Q[N:1]}
//
// Build option
//   RADIX4_PRODREG_EN  when defined, product is a register loaded on sel[4];
//                      otherwise product is combinational from A and Q.
module radix4_datapath #(
  parameter int unsigned N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [4:0]     ld,
  input  logic [4:0]     sel,
  output logic           flag,
  output logic [2*N-1:0] product
);

  localparam int unsigned AW = N + 2;
  localparam int unsigned CW = $clog2(N / 2) + 1;
  localparam logic [CW-1:0] CntInit = CW'(N / 2);

  logic [AW-1:0] m_q, m_d;
  logic [AW-1:0] a_q, a_d;
  logic [N:0]    q_q, q_d;      // q_q[0] is the Booth q(-1) bit
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] m_x2;
  logic [AW-1:0] addend;
  logic [AW-1:0] sum;
  logic [AW-1:0] shift_src;
  logic [2*N-1:0] result;

  // M is sign-extended by two bits, so 2M cannot overflow the AW-bit datapath.
  assign m_x2 = {m_q[AW-2:0], 1'b0};

  // Booth recode of the low three bits of Q.
  always_comb begin
    addend = '0;
    if (sel[0]) begin
      case (q_q[2:0])
        3'b001, 3'b010: addend = m_q;
        3'b011:         addend = m_x2;
        3'b100:         addend = -m_x2;
        3'b101, 3'b110: addend = -m_q;
        default:        addend = '0;
      endcase
    end
  end

  assign sum = a_q + addend;

  always_comb begin
    m_d = ld[0] ? {{2{in_a[N-1]}}, in_a} : m_q;
  end

  // Init wins over accumulate/shift; shift consumes the fresh sum when both are set.
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    shift_src = ld[2] ? sum : a_q;
    if (ld[1]) begin
      a_d = '0;
      q_d = {in_b, 1'b0};
    end else if (ld[3]) begin
      a_d = {{2{shift_src[AW-1]}}, shift_src[AW-1:2]};
      q_d = {shift_src[1:0], q_q[N:2]};
    end else if (ld[2]) begin
      a_d = sum;
    end
  end

  // Decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (ld[4]) begin
      if (sel[1]) begin
        cnt_d = CntInit;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      a_q   <= a_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign flag   = (cnt_q == '0);
  assign result = {a_q[N-1:0], q_q[N:1]};

`ifdef RADIX4_PRODREG_EN
  logic [2*N-1:0] prod_q, prod_d;
  logic [1:0]     unused_sel;

  assign unused_sel = sel[3:2];

  always_comb begin
    prod_d = sel[4] ? result : prod_q;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;
`else
  logic [2:0] unused_sel;

  assign unused_sel = sel[4:2];
  assign product    = result;
`endif

endmodule

// File: tb/tb_radix4_datapath.sv
module tb_radix4_datapath;

  localparam int N = 8;
  localparam int S = N / 2;

  logic           clk = 1'b1;
  logic           rst;
  logic [N-1:0]   in_a, in_b;
  logic [4:0]     ld, sel;
  logic           flag;
  logic [2*N-1:0] product;

  int n_vec = 0;
  int n_err = 0;

  radix4_datapath #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_a    (in_a),
    .in_b    (in_b),
    .ld      (ld),
    .sel     (sel),
    .flag    (flag),
    .product (product)
  );

  always #5 clk = ~clk;

  // Apply strobes for one falling edge, return just after it.
  task automatic cyc(input logic [4:0] l, input logic [4:0] s);
    ld  = l;
    sel = s;
    @(negedge clk);
    #1;
  endtask

  // Reference: signed product of the operands.
  function automatic logic [2*N-1:0] ref_mul(input logic signed [N-1:0] a,
                                            input logic signed [N-1:0] b);
    logic signed [2*N-1:0] e;
    e = a * b;
    return e;
  endfunction

  // Full multiply; fh[0] is flag after load, fh[k] flag after digit k.
  task automatic do_multiply(input logic [N-1:0] a, input logic [N-1:0] b, input bit split,
                             output logic [2*N-1:0] p, output logic [S:0] fh);
    in_a = a;
    in_b = b;
    cyc(5'b10011, 5'b00010);
    fh[0] = flag;
    in_a = N'($urandom);
    in_b = N'($urandom);
    for (int k = 1; k <= S; k++) begin
      if (split) begin
        cyc(5'b00100, 5'b00001);
        cyc(5'b11000, 5'b00000);
      end else begin
        cyc(5'b11100, 5'b00001);
      end
      fh[k] = flag;
    end
    cyc(5'b00000, 5'b10000);
    p = product;
  endtask

  function automatic logic [S:0] flag_exp();
    logic [S:0] f;
    f    = '0;
    f[S] = 1'b1;
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_a = N'($urandom);
      in_b = N'($urandom);
      cyc(5'($urandom), 5'($urandom));
    end
    rst = 1'b0;
    cyc(5'b00000, 5'b00000);
    n_vec++;
    if (flag !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flag: got %b want 1", flag);
    end
    n_vec++;
    if (product !== '0) begin
      n_err++;
      $display("FAIL reset_product: got %h want 0", product);
    end
  endtask

  task automatic test_known();
    logic [2*N-1:0] p;
    logic [S:0]     fh;
    do_multiply(8'sd7, -8'sd3, 1'b0, p, fh);
    n_vec++;
    if (p !== 16'hFFEB) begin
      n_err++;
      $display("FAIL mul_7x-3: got %h want ffeb", p);
    end
    n_vec++;
    if (fh !== flag_exp()) begin
      n_err++;
      $display("FAIL flag_timing: got %b want %b", fh, flag_exp());
    end
  endtask

  task automatic test_corners();
    logic [N-1:0]   ca[3];
    logic [N-1:0]   cb[3];
    logic [2*N-1:0] cp[3];
    logic [2*N-1:0] p;
    logic [S:0]     fh;
    ca = '{8'h80, 8'h80, 8'h00};
    cb = '{8'h80, 8'h7F, 8'hFF};
    cp = '{16'h4000, 16'hC080, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_multiply(ca[i], cb[i], 1'b0, p, fh);
      n_vec++;
      if (p !== cp[i]) begin
        n_err++;
        $display("FAIL corner_%0d: %h x %h got %h want %h", i, ca[i], cb[i], p, cp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   a, b;
    logic [2*N-1:0] p;
    logic [S:0]     fh;
    bit             split;
    for (int i = 0; i < 24; i++) begin
      a     = N'($urandom);
      b     = N'($urandom);
      split = 1'($urandom);
      do_multiply(a, b, split, p, fh);
      n_vec++;
      if (p !== ref_mul(a, b) || fh !== flag_exp()) begin
        n_err++;
        $display("FAIL random_%0d: %h x %h split=%0d got %h flags %b want %h flags %b",
                 i, a, b, split, p, fh, ref_mul(a, b), flag_exp());
      end
    end
  endtask

  task automatic test_saturation();
    int cnt_model;
    // Counter is at zero after the previous multiply.
    for (int i = 0; i < 3; i++) begin
      cyc(5'b10000, 5'b00000);
      n_vec++;
      if (flag !== 1'b1) begin
        n_err++;
        $display("FAIL sat_dec_%0d: flag got %b want 1", i, flag);
      end
    end
    cyc(5'b10000, 5'b00010);
    cnt_model = S;
    while (cnt_model > 0) begin
      cyc(5'b10000, 5'b00000);
      cnt_model--;
      n_vec++;
      if (flag !== (cnt_model == 0)) begin
        n_err++;
        $display("FAIL count_down_%0d: flag got %b want %b", cnt_model, flag, cnt_model == 0);
      end
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] b;
    // A holds a nonzero partial product first.
    in_a = 8'h55;
    in_b = 8'h3B;
    cyc(5'b10011, 5'b00010);
    cyc(5'b11100, 5'b00001);
    b    = N'($urandom);
    in_b = b;
    cyc(5'b01110, 5'b00001);
    cyc(5'b00000, 5'b10000);
    n_vec++;
    if (product !== {{N{1'b0}}, b}) begin
      n_err++;
      $display("FAIL priority: got %h want %h", product, {{N{1'b0}}, b});
    end
  endtask

  task automatic test_m_independent();
    logic [N-1:0]   a, b;
    a    = N'($urandom);
    b    = N'($urandom);
    in_a = a;
    cyc(5'b00001, 5'b00000);
    in_a = ~a;
    cyc(5'b00000, 5'b00000);
    in_b = b;
    cyc(5'b10010, 5'b00010);
    for (int k = 0; k < S; k++) cyc(5'b11100, 5'b00001);
    cyc(5'b00000, 5'b10000);
    n_vec++;
    if (product !== ref_mul(a, b)) begin
      n_err++;
      $display("FAIL m_separate_load: got %h want %h", product, ref_mul(a, b));
    end
  endtask

  task automatic test_reset_mid();
    logic [2*N-1:0] p;
    logic [S:0]     fh;
    in_a = 8'h6D;
    in_b = 8'hA3;
    cyc(5'b10011, 5'b00010);
    cyc(5'b11100, 5'b00001);
    cyc(5'b11100, 5'b10001);
    rst = 1'b1;
    cyc(5'b11111, 5'b11111);
    rst = 1'b0;
    cyc(5'b00000, 5'b00000);
    n_vec++;
    if (flag !== 1'b1 || product !== '0) begin
      n_err++;
      $display("FAIL reset_mid: flag %b product %h want 1 / 0", flag, product);
    end
    do_multiply(8'hC5, 8'h2E, 1'b0, p, fh);
    n_vec++;
    if (p !== ref_mul(8'hC5, 8'h2E)) begin
      n_err++;
      $display("FAIL after_reset_mul: got %h want %h", p, ref_mul(8'hC5, 8'hC5 ^ 8'hEB));
    end
  endtask

`ifdef RADIX4_PRODREG_EN
  task automatic test_capture();
    logic [2*N-1:0] p1;
    logic [S:0]     fh;
    logic [N-1:0]   a, b;
    bit             held;
    do_multiply(8'h13, 8'hF9, 1'b0, p1, fh);
    a    = N'($urandom);
    b    = N'($urandom);
    in_a = a;
    in_b = b;
    held = 1'b1;
    cyc(5'b10011, 5'b00010);
    if (product !== p1) held = 1'b0;
    for (int k = 0; k < S; k++) begin
      cyc(5'b11100, 5'b00001);
      if (product !== p1) held = 1'b0;
    end
    n_vec++;
    if (!held) begin
      n_err++;
      $display("FAIL capture_hold: product %h want held %h", product, p1);
    end
    cyc(5'b00000, 5'b10000);
    n_vec++;
    if (product !== ref_mul(a, b)) begin
      n_err++;
      $display("FAIL capture_new: got %h want %h", product, ref_mul(a, b));
    end
  endtask
`else
  task automatic test_transparent();
    logic [N-1:0] b;
    b    = N'($urandom);
    in_b = b;
    cyc(5'b00010, 5'b00000);
    n_vec++;
    if (product !== {{N{1'b0}}, b}) begin
      n_err++;
      $display("FAIL comb_product: got %h want %h", product, {{N{1'b0}}, b});
    end
  endtask
`endif

  initial begin
    rst  = 1'b1;
    ld   = '0;
    sel  = '0;
    in_a = '0;
    in_b = '0;
    #2;
    test_reset();
    test_known();
    test_corners();
    test_saturation();
    test_priority();
    test_m_independent();
    test_random();
    test_reset_mid();
`ifdef RADIX4_PRODREG_EN
    test_capture();
`else
    test_transparent();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
